// File: rtl/pong_pkg.sv
// Shared definitions for the ball engine: FSM state encoding and winner codes.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pad_hit.sv
// Paddle collision detector. TOP=1 models paddle 1, which is struck from below
// by a rising ball. TOP=0 models paddle 2, which is struck from above by a
// falling ball. All coordinate math uses one extra bit so that pad+width
// cannot wrap.
module pad_hit #(
    parameter int COORD_W = 7,
    parameter int PAD_W   = 6,
    parameter bit TOP     = 1'b1
) (
    input  logic [COORD_W-1:0] x_ball,
    input  logic [COORD_W-1:0] y_ball,
    input  logic [COORD_W-1:0] x_pad,
    input  logic [COORD_W-1:0] y_pad,
    input  logic               dir_up,
    output logic               hit,
    output logic               left_half
);
    localparam int EW = COORD_W + 1;

    logic [EW-1:0] xb, yb, xp, yp, x_end, x_mid;
    logic          row_ok, dir_ok, in_span;

    // Widen coordinates, then test row adjacency, travel direction and horizontal span.
    always_comb begin
        xb    = {1'b0, x_ball};
        yb    = {1'b0, y_ball};
        xp    = {1'b0, x_pad};
        yp    = {1'b0, y_pad};
        x_end = xp + EW'(PAD_W);
        x_mid = xp + EW'(PAD_W / 2);
        if (TOP) begin
            row_ok = (yb == yp + EW'(1));
            dir_ok = dir_up;
        end else begin
            // Compare yb+1 against yp rather than yb against yp-1 so a pad at row 0 cannot underflow.
            row_ok = (yb + EW'(1) == yp);
            dir_ok = ~dir_up;
        end
        in_span   = (xb >= xp) && (xb < x_end);
        hit       = row_ok & dir_ok & in_span;
        left_half = (xb < x_mid);
    end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine. The FSM has three states:
//   SERVE     - holds the ball at the centre while it counts ticks.
//   PLAY      - moves the ball one cell per tick and resolves collisions.
//   GAME_OVER - freezes play until restart is asserted.
module ball_engine
    import pong_pkg::*;
#(
    parameter int COORD_W     = 7,
    parameter int X_LIMIT     = 54,
    parameter int Y_LIMIT     = 47,
    parameter int PAD_W       = 6,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               pause,
    input  logic               restart,
    input  logic [COORD_W-1:0] x_pad1,
    input  logic [COORD_W-1:0] y_pad1,
    input  logic [COORD_W-1:0] x_pad2,
    input  logic [COORD_W-1:0] y_pad2,
    output logic [COORD_W-1:0] x_ball,
    output logic [COORD_W-1:0] y_ball,
    output logic               dir_right,
    output logic               dir_up,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               point1,
    output logic               point2,
    output logic               game_over,
    output logic [1:0]         winner
);
    localparam int CNT_W = $clog2(SERVE_TICKS + 1);

    localparam logic [COORD_W-1:0] X_C   = COORD_W'(X_LIMIT / 2);
    localparam logic [COORD_W-1:0] Y_C   = COORD_W'(Y_LIMIT / 2);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(X_LIMIT);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(Y_LIMIT);
    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dr_q, dr_d, du_q, du_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic               p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         win_q, win_d;

    logic               hit1, left1, hit2, left2;
    logic               step_right;
    logic [SCORE_W-1:0] s1_inc, s2_inc;

    assign s1_inc = s1_q + SCORE_W'(1);
    assign s2_inc = s2_q + SCORE_W'(1);

    pad_hit #(.COORD_W(COORD_W), .PAD_W(PAD_W), .TOP(1'b1)) u_hit1 (
        .x_ball    (x_q),
        .y_ball    (y_q),
        .x_pad     (x_pad1),
        .y_pad     (y_pad1),
        .dir_up    (du_q),
        .hit       (hit1),
        .left_half (left1)
    );

    pad_hit #(.COORD_W(COORD_W), .PAD_W(PAD_W), .TOP(1'b0)) u_hit2 (
        .x_ball    (x_q),
        .y_ball    (y_q),
        .x_pad     (x_pad2),
        .y_pad     (y_pad2),
        .dir_up    (du_q),
        .hit       (hit2),
        .left_half (left2)
    );

    // State register: all game state, asynchronously returned to the serve position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SERVE;
            cnt_q   <= '0;
            x_q     <= X_C;
            y_q     <= Y_C;
            dr_q    <= 1'b1;
            du_q    <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            win_q   <= WIN_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dr_q    <= dr_d;
            du_q    <= du_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
        end
    end

    // Next-state logic: serve countdown, prioritised collision resolution, scoring and restart.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        dr_d       = dr_q;
        du_d       = du_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        p1_d       = 1'b0;
        p2_d       = 1'b0;
        win_d      = win_q;
        step_right = dr_q;

        case (state_q)
            ST_SERVE: begin
                x_d = X_C;
                y_d = Y_C;
                if (tick && !pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (tick && !pause) begin
                    if (hit1) begin
                        du_d = 1'b0;
                        dr_d = ~left1;
                        y_d  = y_q + ONE_C;
                        x_d  = left1 ? x_q - ONE_C : x_q + ONE_C;
                    end else if (hit2) begin
                        du_d = 1'b1;
                        dr_d = ~left2;
                        y_d  = y_q - ONE_C;
                        x_d  = left2 ? x_q - ONE_C : x_q + ONE_C;
                    end else if (y_q == Y_MAX) begin
                        // Player 1 scored: re-serve down and right toward player 2.
                        s1_d  = s1_inc;
                        p1_d  = 1'b1;
                        x_d   = X_C;
                        y_d   = Y_C;
                        du_d  = 1'b0;
                        dr_d  = 1'b1;
                        cnt_d = '0;
                        if (s1_inc == WIN_S) begin
                            state_d = ST_GAME_OVER;
                            win_d   = WIN_P1;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else if (y_q == '0) begin
                        // Player 2 scored: re-serve up and left toward player 1.
                        s2_d  = s2_inc;
                        p2_d  = 1'b1;
                        x_d   = X_C;
                        y_d   = Y_C;
                        du_d  = 1'b1;
                        dr_d  = 1'b0;
                        cnt_d = '0;
                        if (s2_inc == WIN_S) begin
                            state_d = ST_GAME_OVER;
                            win_d   = WIN_P2;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        // Side walls only flip horizontal travel; free motion shares the same step.
                        if (x_q == X_MAX) begin
                            step_right = 1'b0;
                        end else if (x_q == ONE_C) begin
                            step_right = 1'b1;
                        end
                        dr_d = step_right;
                        x_d  = step_right ? x_q + ONE_C : x_q - ONE_C;
                        y_d  = du_q ? y_q - ONE_C : y_q + ONE_C;
                    end
                end
            end

            ST_GAME_OVER: begin
                x_d = X_C;
                y_d = Y_C;
                if (restart) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                    s1_d    = '0;
                    s2_d    = '0;
                    win_d   = WIN_NONE;
                    dr_d    = 1'b1;
                    du_d    = 1'b0;
                end
            end

            default: begin
                state_d = ST_SERVE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: game_over follows the state; everything else is a registered copy.
    always_comb begin
        game_over = (state_q == ST_GAME_OVER);
        x_ball    = x_q;
        y_ball    = y_q;
        dir_right = dr_q;
        dir_up    = du_q;
        score1    = s1_q;
        score2    = s2_q;
        point1    = p1_q;
        point2    = p2_q;
        winner    = win_q;
    end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the game rules.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       pause = 1'b0;
    logic       restart = 1'b0;
    logic [6:0] x_pad1 = 7'd0, y_pad1 = 7'd60, x_pad2 = 7'd0, y_pad2 = 7'd100;
    logic [6:0] x_ball, y_ball;
    logic       dir_right, dir_up;
    logic [3:0] score1, score2;
    logic       point1, point2, game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    // Game model: mode 0 = waiting to serve, 1 = ball in play, 2 = match finished.
    int m_mode, m_cnt, m_x, m_y, m_dr, m_du, m_s1, m_s2, m_p1, m_p2, m_win;

    ball_engine dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .pause     (pause),
        .restart   (restart),
        .x_pad1    (x_pad1),
        .y_pad1    (y_pad1),
        .x_pad2    (x_pad2),
        .y_pad2    (y_pad2),
        .x_ball    (x_ball),
        .y_ball    (y_ball),
        .dir_right (dir_right),
        .dir_up    (dir_up),
        .score1    (score1),
        .score2    (score2),
        .point1    (point1),
        .point2    (point2),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_x = 27; m_y = 23; m_dr = 1; m_du = 0;
        m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
    endtask

    task automatic model_point(input int who);
        m_x = 27; m_y = 23; m_cnt = 0;
        if (who == 1) begin
            m_s1 = m_s1 + 1; m_p1 = 1; m_du = 0; m_dr = 1;
            if (m_s1 == 9) begin m_mode = 2; m_win = 1; end else m_mode = 0;
        end else begin
            m_s2 = m_s2 + 1; m_p2 = 1; m_du = 1; m_dr = 0;
            if (m_s2 == 9) begin m_mode = 2; m_win = 2; end else m_mode = 0;
        end
    endtask

    // One clock of game rules applied to the inputs presented for that clock.
    task automatic model_step(input logic t, input logic p, input logic r);
        int a1, b1, a2, b2;
        a1 = int'(x_pad1); b1 = int'(y_pad1); a2 = int'(x_pad2); b2 = int'(y_pad2);
        m_p1 = 0; m_p2 = 0;
        if (m_mode == 2) begin
            if (r) begin
                m_mode = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dr = 1; m_du = 0;
            end
        end else if (t && !p) begin
            if (m_mode == 0) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 16) begin m_cnt = 0; m_mode = 1; end
            end else begin
                if (m_du == 1 && m_y == b1 + 1 && m_x >= a1 && m_x < a1 + 6) begin
                    m_du = 0; m_dr = (m_x >= a1 + 3) ? 1 : 0;
                    m_y = m_y + 1; m_x = m_x + (m_dr ? 1 : -1);
                end else if (m_du == 0 && m_y == b2 - 1 && m_x >= a2 && m_x < a2 + 6) begin
                    m_du = 1; m_dr = (m_x >= a2 + 3) ? 1 : 0;
                    m_y = m_y - 1; m_x = m_x + (m_dr ? 1 : -1);
                end else if (m_y == 47) begin
                    model_point(1);
                end else if (m_y == 0) begin
                    model_point(2);
                end else begin
                    if (m_x == 54) m_dr = 0;
                    else if (m_x == 1) m_dr = 1;
                    m_x = m_x + (m_dr ? 1 : -1);
                    m_y = m_y + (m_du ? -1 : 1);
                end
                m_x = m_x & 127;
                m_y = m_y & 127;
            end
        end
    endtask

    // Present inputs for one clock (called at negedge), return at the following negedge.
    task automatic step(input logic t, input logic p, input logic r);
        tick = t; pause = p; restart = r;
        model_step(t, p, r);
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0; pause = 1'b0; restart = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        x_pad1 = 7'd0; y_pad1 = 7'd60; x_pad2 = 7'd0; y_pad2 = 7'd100;
        do_reset();
        checks++;
        if ({x_ball, y_ball} !== {7'd27, 7'd23}) begin
            errors++; $display("FAIL reset_ball: got (%0d,%0d) want (27,23)", x_ball, y_ball);
        end
        checks++;
        if ({dir_right, dir_up} !== 2'b10) begin
            errors++; $display("FAIL reset_dir: got r=%b u=%b want r=1 u=0", dir_right, dir_up);
        end
        checks++;
        if ({score1, score2, point1, point2, game_over, winner} !== 13'd0) begin
            errors++; $display("FAIL reset_score: got s1=%0d s2=%0d p1=%b p2=%b go=%b win=%b want all zero",
                               score1, score2, point1, point2, game_over, winner);
        end
    endtask

    task automatic test_serve();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        ticks(15);
        checks++;
        if ({x_ball, y_ball} !== {7'd27, 7'd23}) begin
            errors++; $display("FAIL serve_hold16: got (%0d,%0d) want (27,23)", x_ball, y_ball);
        end
        ticks(1);
        checks++;
        if ({x_ball, y_ball} !== {7'd28, 7'd24}) begin
            errors++; $display("FAIL serve_tick17: got (%0d,%0d) want (28,24)", x_ball, y_ball);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ticks(20);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({x_ball, y_ball, dir_right, dir_up} !== {7'd27, 7'd23, 2'b10}) begin
            errors++; $display("FAIL async_reset: got (%0d,%0d) r=%b u=%b want (27,23) r=1 u=0",
                               x_ball, y_ball, dir_right, dir_up);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Serve then 23 play ticks puts the ball at (50,46) heading down-right; paddle 2 returns it.
    task automatic test_pad2_hit(input int xp, input int exp_x, input logic exp_dr);
        x_pad2 = 7'd0; y_pad2 = 7'd100;
        do_reset();
        ticks(39);
        checks++;
        if ({x_ball, y_ball} !== {7'd50, 7'd46}) begin
            errors++; $display("FAIL pad2_approach: got (%0d,%0d) want (50,46)", x_ball, y_ball);
        end
        x_pad2 = 7'(xp); y_pad2 = 7'd47;
        ticks(1);
        checks++;
        if ({x_ball, y_ball, dir_up, dir_right} !== {7'(exp_x), 7'd45, 1'b1, exp_dr}) begin
            errors++; $display("FAIL pad2_hit_x%0d: got (%0d,%0d) u=%b r=%b want (%0d,45) u=1 r=%b",
                               xp, x_ball, y_ball, dir_up, dir_right, exp_x, exp_dr);
        end
    endtask

    // Continues the right-half return: (51,45) up-right reaches the wall at x=54.
    task automatic test_wall();
        ticks(3);
        checks++;
        if ({x_ball, y_ball} !== {7'd54, 7'd42}) begin
            errors++; $display("FAIL wall_approach: got (%0d,%0d) want (54,42)", x_ball, y_ball);
        end
        ticks(1);
        checks++;
        if ({x_ball, y_ball, dir_right, dir_up} !== {7'd53, 7'd41, 2'b01}) begin
            errors++; $display("FAIL wall_bounce: got (%0d,%0d) r=%b u=%b want (53,41) r=0 u=1",
                               x_ball, y_ball, dir_right, dir_up);
        end
    endtask

    // Paddle at 44 covers 44..49, so the ball at x=50 slips past and reaches the bottom goal.
    task automatic test_goal_p1();
        x_pad2 = 7'd0; y_pad2 = 7'd100;
        do_reset();
        ticks(39);
        x_pad2 = 7'd44; y_pad2 = 7'd47;
        ticks(1);
        checks++;
        if ({x_ball, y_ball} !== {7'd51, 7'd47}) begin
            errors++; $display("FAIL pad2_edge_miss: got (%0d,%0d) want (51,47)", x_ball, y_ball);
        end
        ticks(1);
        checks++;
        if ({score1, score2, point1, point2, x_ball, y_ball} !== {4'd1, 4'd0, 2'b10, 7'd27, 7'd23}) begin
            errors++; $display("FAIL goal_p1: got s1=%0d s2=%0d p1=%b p2=%b (%0d,%0d) want s1=1 s2=0 p1=1 p2=0 (27,23)",
                               score1, score2, point1, point2, x_ball, y_ball);
        end
        checks++;
        if ({dir_right, dir_up, game_over} !== 3'b100) begin
            errors++; $display("FAIL goal_p1_serve_dir: got r=%b u=%b go=%b want r=1 u=0 go=0",
                               dir_right, dir_up, game_over);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (point1 !== 1'b0) begin
            errors++; $display("FAIL point1_width: got %b want 0", point1);
        end
        ticks(15);
        checks++;
        if ({x_ball, y_ball, score1} !== {7'd27, 7'd23, 4'd1}) begin
            errors++; $display("FAIL goal_p1_reserve: got (%0d,%0d) s1=%0d want (27,23) s1=1",
                               x_ball, y_ball, score1);
        end
    endtask

    task automatic test_game_over();
        int budget;
        x_pad2 = 7'd0; y_pad2 = 7'd100;
        do_reset();
        ticks(39);
        x_pad2 = 7'd48; y_pad2 = 7'd47;
        ticks(1);
        x_pad2 = 7'd0; y_pad2 = 7'd100;
        budget = 3000;
        while (game_over !== 1'b1 && budget > 0) begin
            ticks(1);
            budget--;
        end
        checks++;
        if (game_over !== 1'b1) begin
            errors++; $display("FAIL game_over_timeout: got go=%b s2=%0d want go=1", game_over, score2);
        end
        checks++;
        if ({winner, score1, score2, point2, x_ball, y_ball} !== {2'b10, 4'd0, 4'd9, 1'b1, 7'd27, 7'd23}) begin
            errors++; $display("FAIL game_over_state: got win=%b s1=%0d s2=%0d p2=%b (%0d,%0d) want win=10 s1=0 s2=9 p2=1 (27,23)",
                               winner, score1, score2, point2, x_ball, y_ball);
        end
        ticks(30);
        checks++;
        if ({game_over, score2, x_ball, y_ball} !== {1'b1, 4'd9, 7'd27, 7'd23}) begin
            errors++; $display("FAIL game_over_frozen: got go=%b s2=%0d (%0d,%0d) want go=1 s2=9 (27,23)",
                               game_over, score2, x_ball, y_ball);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if ({game_over, winner, score1, score2} !== 11'd0) begin
            errors++; $display("FAIL restart: got go=%b win=%b s1=%0d s2=%0d want all zero",
                               game_over, winner, score1, score2);
        end
        ticks(16);
        checks++;
        if ({x_ball, y_ball} !== {7'd27, 7'd23}) begin
            errors++; $display("FAIL restart_serve_hold: got (%0d,%0d) want (27,23)", x_ball, y_ball);
        end
        ticks(1);
        checks++;
        if ({x_ball, y_ball} !== {7'd28, 7'd24}) begin
            errors++; $display("FAIL restart_serve_go: got (%0d,%0d) want (28,24)", x_ball, y_ball);
        end
    endtask

    task automatic test_reset_mid_serve();
        do_reset();
        ticks(10);
        do_reset();
        ticks(16);
        checks++;
        if ({x_ball, y_ball} !== {7'd27, 7'd23}) begin
            errors++; $display("FAIL reset_serve_count: got (%0d,%0d) want (27,23)", x_ball, y_ball);
        end
        ticks(1);
        checks++;
        if ({x_ball, y_ball} !== {7'd28, 7'd24}) begin
            errors++; $display("FAIL reset_serve_go: got (%0d,%0d) want (28,24)", x_ball, y_ball);
        end
    endtask

    task automatic test_random();
        logic [28:0] obs, exp_v;
        int          bad = 0;
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if (i % 40 == 0) begin
                x_pad1 = 7'($urandom_range(0, 48));
                y_pad1 = 7'($urandom_range(0, 4));
                x_pad2 = 7'($urandom_range(0, 48));
                y_pad2 = 7'($urandom_range(43, 47));
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0));
            obs   = {x_ball, y_ball, dir_right, dir_up, score1, score2, point1, point2, game_over, winner};
            exp_v = {7'(m_x), 7'(m_y), 1'(m_dr), 1'(m_du), 4'(m_s1), 4'(m_s2), 1'(m_p1), 1'(m_p2),
                     1'(m_mode == 2), 2'(m_win)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_v);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve();
        test_async_reset();
        test_pad2_hit(48, 49, 1'b0);
        test_pad2_hit(47, 51, 1'b1);
        test_wall();
        test_goal_p1();
        test_game_over();
        test_reset_mid_serve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter COORD_W, default 7, bit width of every coordinate.
REQ-002 SHALL have parameter X_LIMIT, default 54, rightmost playable ball column.
REQ-003 SHALL have parameter Y_LIMIT, default 47, bottom goal row.
REQ-004 SHALL have parameter PAD_W, default 6, paddle width in cells; even, >=2.
REQ-005 SHALL have parameter SCORE_W, default 4, score counter width.
REQ-006 SHALL have parameter WIN_SCORE, default 9, points that end a match; < 2**SCORE_W.
REQ-007 SHALL have parameter SERVE_TICKS, default 16, ticks the ball is held before a serve.
REQ-008 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-009 SHALL have ports: tick in 1, movement strobe, one clk wide; pause in 1, freezes play; restart in 1, leaves GAME_OVER.
REQ-010 SHALL have ports: x_pad1, y_pad1, x_pad2, y_pad2 in COORD_W, paddle left cells and rows; paddle 1 defends the top, paddle 2 the bottom.
REQ-011 SHALL have ports: x_ball, y_ball out COORD_W, ball cell; dir_right, dir_up out 1, direction flags.
REQ-012 SHALL have ports: score1, score2 out SCORE_W; point1, point2 out 1, one-clk score pulses; game_over out 1; winner out 2 (00 none, 01 p1, 10 p2).

Function
REQ-013 SHALL run an FSM with states SERVE, PLAY, GAME_OVER, updating only on clk edges where tick=1, except restart.
REQ-014 SERVE SHALL hold the ball at (X_LIMIT/2, Y_LIMIT/2), count ticks, and enter PLAY on the SERVE_TICKS-th tick with no ball motion on that tick.
REQ-015 PLAY with pause=1 SHALL hold all state, including the serve counter when in SERVE.
REQ-016 PLAY on tick SHALL evaluate in strict priority: paddle 1 hit, paddle 2 hit, bottom goal, top goal, side wall, free motion.
REQ-017 Paddle 1 hit SHALL occur when y_ball==y_pad1+1, dir_up=1 and x_pad1<=x_ball<x_pad1+PAD_W. Ball goes down (dir_up=0) by one row. The left half sends it left; the right half sends it right.
REQ-018 Paddle 2 hit SHALL mirror REQ-017 with y_ball==y_pad2-1, dir_up=0, result dir_up=1.
REQ-019 y_ball==Y_LIMIT SHALL award player 1 (score1+1, point1 pulse). y_ball==0 SHALL award player 2.
REQ-020 After a point, the ball SHALL return to centre and the FSM to SERVE. The serve direction is toward the conceding player, horizontally right if player 1 scored, else left.
REQ-021 x_ball==X_LIMIT SHALL force dir_right=0 and x_ball==1 SHALL force dir_right=1 on that tick, with the step applied in the new direction and vertical motion unchanged.
REQ-022 Free motion SHALL step x and y by exactly one cell each per tick according to dir_right and dir_up.
REQ-023 A score reaching WIN_SCORE SHALL enter GAME_OVER in the same clk, set game_over=1 and winner, and freeze the ball at centre.
REQ-024 GAME_OVER SHALL ignore tick; restart=1 SHALL clear scores and winner and enter SERVE on the next clk. restart in other states SHALL be ignored.
REQ-025 Paddle-coordinate arithmetic SHALL be done at COORD_W+1 bits so x_pad+PAD_W does not wrap.

Reset
REQ-026 reset=1 SHALL asynchronously force: state SERVE, serve counter 0, ball centre, dir_right=1, dir_up=0, scores 0, pulses 0, game_over 0, winner 00.
REQ-027 Reset asserted mid-PLAY or mid-GAME_OVER SHALL behave identically to power-up reset. Play resumes only after reset deasserts and SERVE_TICKS ticks elapse.

Structure
REQ-028 The FSM state encoding and the winner codes SHALL live in shared package pong_pkg.
REQ-029 Collision detection SHALL be a sub-module pad_hit, instantiated once per paddle, outputting hit, left_half.

Verification
REQ-030 Reset, then 16 ticks: ball stays at (27,23); on tick 17 the ball is at (28,24).
REQ-031 Ball at (30,46) with dir_up=0, pad2 at x=28,y=47, tick: ball at (29,45), dir_up=1, dir_right=0 (left half).
REQ-032 Ball at (33,46) with the same paddle, tick: ball at (34,45), dir_right=1 (right half).
REQ-033 Ball at (10,47), no paddle, tick: score1=1, point1 high exactly 1 clk, ball at (27,23), state SERVE.
REQ-034 Ball at (54,10) with dir_right=1, dir_up=1, tick: ball at (53,9), dir_right=0.
REQ-035 score2=8, ball reaches y=0: game_over=1, winner=10, and ticks are ignored. restart: scores 0 and SERVE; reset during SERVE count: counter restarts at 0.
